// File: rtl/hdmi_period_scheduler_if.sv
// Signal bundle between the timing generator / packet source and the HDMI period scheduler.
// The scheduler takes the slave view; the master view drives the raw stream.
interface hdmi_period_scheduler_if;
   logic        de_in;
   logic        hsync_in;
   logic        vsync_in;
   logic [23:0] pixel_in;
   logic        pkt_valid;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [23:0] pixel_out;
   logic [2:0]  mode;
   logic [3:0]  ctl;
   logic        pkt_ready;
   logic [4:0]  pkt_idx;

   modport master (
      output de_in, hsync_in, vsync_in, pixel_in, pkt_valid,
      input  de_out, hsync_out, vsync_out, pixel_out, mode, ctl, pkt_ready, pkt_idx
   );

   modport slave (
      input  de_in, hsync_in, vsync_in, pixel_in, pkt_valid,
      output de_out, hsync_out, vsync_out, pixel_out, mode, ctl, pkt_ready, pkt_idx
   );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// Delays the raw video stream by DELAY clocks and uses the look-ahead to place video
// preambles/guards and single-packet data islands in horizontal blanking.
module hdmi_period_scheduler #(
   parameter int   DELAY     = 64,
   parameter logic SYNC_IDLE = 1'b1
) (
   input logic                    pixel_clk,
   input logic                    rst,
   hdmi_period_scheduler_if.slave bus
);
   typedef enum logic [2:0] {
      CTRL     = 3'd0,
      VPRE     = 3'd1,
      VGUARD   = 3'd2,
      VIDEO    = 3'd3,
      DPRE     = 3'd4,
      DGUARD_L = 3'd5,
      DDATA    = 3'd6,
      DGUARD_T = 3'd7
   } mode_t;

   localparam int WIN_W   = $clog2(DELAY + 1);
   localparam int STAGE_W = 27;
   localparam logic [STAGE_W-1:0] STAGE_RST = {1'b0, SYNC_IDLE, SYNC_IDLE, 24'd0};

   logic [STAGE_W-1:0] line_reg [DELAY];
   logic [WIN_W-1:0]   win_reg;
   mode_t              mode_reg, mode_next;
   logic [4:0]         cnt_reg, cnt_next;
   logic [3:0]         ctrl_run_reg, ctrl_run_next;
   logic [3:0]         ctl_reg, ctl_next;
   logic               pkt_ready_reg, pkt_ready_next;
   logic [4:0]         pkt_idx_reg, pkt_idx_next;
   logic               de_next, vid_edge, idle, start_island;

   // Decisions are made one clock early, so taps are one stage closer to the input.
   assign de_next  = line_reg[DELAY-2][STAGE_W-1];
   assign vid_edge = line_reg[DELAY-12][STAGE_W-1] & ~line_reg[DELAY-11][STAGE_W-1];

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DELAY; i++) line_reg[i] <= STAGE_RST;
      end else begin
         line_reg[0] <= {bus.de_in, bus.hsync_in, bus.vsync_in, bus.pixel_in};
         for (int i = 1; i < DELAY; i++) line_reg[i] <= line_reg[i-1];
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         win_reg       <= '0;
         mode_reg      <= CTRL;
         cnt_reg       <= '0;
         ctrl_run_reg  <= '0;
         ctl_reg       <= '0;
         pkt_ready_reg <= 1'b0;
         pkt_idx_reg   <= '0;
      end else begin
         win_reg       <= win_reg + WIN_W'(bus.de_in) - WIN_W'(de_next);
         mode_reg      <= mode_next;
         cnt_reg       <= cnt_next;
         ctrl_run_reg  <= ctrl_run_next;
         ctl_reg       <= ctl_next;
         pkt_ready_reg <= pkt_ready_next;
         pkt_idx_reg   <= pkt_idx_next;
      end
   end

   always_comb begin
      mode_next      = CTRL;
      cnt_next       = '0;
      idle           = 1'b0;
      start_island   = 1'b0;
      ctl_next       = 4'b0000;
      pkt_idx_next   = '0;
      ctrl_run_next  = '0;
      if (de_next) begin
         mode_next = VIDEO;
      end else begin
         unique case (mode_reg)
            VPRE: begin
               if (cnt_reg == 5'd7) mode_next = VGUARD;
               else begin mode_next = VPRE; cnt_next = cnt_reg + 5'd1; end
            end
            VGUARD: begin
               if (cnt_reg == 5'd1) idle = 1'b1;
               else begin mode_next = VGUARD; cnt_next = cnt_reg + 5'd1; end
            end
            DPRE: begin
               if (cnt_reg == 5'd7) mode_next = DGUARD_L;
               else begin mode_next = DPRE; cnt_next = cnt_reg + 5'd1; end
            end
            DGUARD_L: begin
               if (cnt_reg == 5'd1) mode_next = DDATA;
               else begin mode_next = DGUARD_L; cnt_next = cnt_reg + 5'd1; end
            end
            DDATA: begin
               if (cnt_reg == 5'd31) mode_next = DGUARD_T;
               else begin mode_next = DDATA; cnt_next = cnt_reg + 5'd1; end
            end
            DGUARD_T: begin
               if (cnt_reg == 5'd1) idle = 1'b1;
               else begin mode_next = DGUARD_T; cnt_next = cnt_reg + 5'd1; end
            end
            default: idle = 1'b1;
         endcase
      end
      // An empty window keeps de low long enough for a full island plus the next preamble.
      if (idle) begin
         if (vid_edge) begin
            mode_next = VPRE;
         end else if (ctrl_run_reg >= 4'd4 && bus.pkt_valid && win_reg == '0) begin
            mode_next    = DPRE;
            start_island = 1'b1;
         end
      end
      if (mode_next == VPRE) ctl_next = 4'b0001;
      if (mode_next == DPRE) ctl_next = 4'b0101;
      if (mode_next == DDATA) pkt_idx_next = cnt_next;
      if (mode_next == CTRL) ctrl_run_next = (ctrl_run_reg == 4'd15) ? 4'd15 : ctrl_run_reg + 4'd1;
      pkt_ready_next = start_island;
   end

   assign bus.de_out    = line_reg[DELAY-1][26];
   assign bus.hsync_out = line_reg[DELAY-1][25];
   assign bus.vsync_out = line_reg[DELAY-1][24];
   assign bus.pixel_out = line_reg[DELAY-1][23:0];
   assign bus.mode      = mode_reg;
   assign bus.ctl       = ctl_reg;
   assign bus.pkt_ready = pkt_ready_reg;
   assign bus.pkt_idx   = pkt_idx_reg;
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: logs every output cycle, then checks
// latency, preambles, island sequences and reset behaviour against hand-derived offsets.
module tb_hdmi_period_scheduler;
   localparam int DELAY = 64;
   localparam int N     = 4096;

   logic pixel_clk = 1'b0;
   logic rst       = 1'b1;
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   last_idx  = 0;
   logic pv_cur    = 1'b0;
   logic drop_on_accept = 1'b0;

   hdmi_period_scheduler_if bus ();

   hdmi_period_scheduler #(.DELAY(DELAY), .SYNC_IDLE(1'b1)) dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .bus       (bus)
   );

   always #5 pixel_clk = ~pixel_clk;
   always @(posedge pixel_clk) cyc <= cyc + 1;

   logic        lg_de [N];
   logic        lg_hs [N];
   logic        lg_vs [N];
   logic [23:0] lg_pix [N];
   logic [2:0]  lg_mode [N];
   logic [3:0]  lg_ctl [N];
   logic        lg_rdy [N];
   logic [4:0]  lg_idx [N];
   logic [23:0] in_pix [N];
   logic        in_hs [N];
   logic        in_vs [N];

   // Output at log index i corresponds to input driven at log index i-DELAY.
   always @(negedge pixel_clk) begin
      if (cyc < N) begin
         lg_de[cyc]   <= bus.de_out;
         lg_hs[cyc]   <= bus.hsync_out;
         lg_vs[cyc]   <= bus.vsync_out;
         lg_pix[cyc]  <= bus.pixel_out;
         lg_mode[cyc] <= bus.mode;
         lg_ctl[cyc]  <= bus.ctl;
         lg_rdy[cyc]  <= bus.pkt_ready;
         lg_idx[cyc]  <= bus.pkt_idx;
      end
   end

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @%0d: observed %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   task automatic drive(input logic de);
      @(negedge pixel_clk);
      if (drop_on_accept && bus.pkt_ready === 1'b1) pv_cur = 1'b0;
      bus.de_in     = de;
      bus.hsync_in  = 1'($urandom_range(0, 1));
      bus.vsync_in  = 1'($urandom_range(0, 1));
      bus.pixel_in  = 24'($urandom);
      bus.pkt_valid = pv_cur;
      last_idx = cyc;
      if (cyc < N) begin
         in_pix[cyc] = bus.pixel_in;
         in_hs[cyc]  = bus.hsync_in;
         in_vs[cyc]  = bus.vsync_in;
      end
   endtask

   task automatic seg(input int n, input logic de);
      for (int i = 0; i < n; i++) drive(de);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_de"}, cyc, bus.de_out, 0);
      chk({tag, "_hs"}, cyc, bus.hsync_out, 1);
      chk({tag, "_vs"}, cyc, bus.vsync_out, 1);
      chk({tag, "_pix"}, cyc, bus.pixel_out, 0);
      chk({tag, "_mode"}, cyc, bus.mode, 0);
      chk({tag, "_ctl"}, cyc, bus.ctl, 0);
      chk({tag, "_rdy"}, cyc, bus.pkt_ready, 0);
      chk({tag, "_idx"}, cyc, bus.pkt_idx, 0);
   endtask

   initial begin
      int a_s, b_act, c_bl, d_bl, d_act, e_bl, t0, b0, cnt, k_rdy;
      int exp_mode, exp_ctl, exp_idx;
      logic found;
      bus.de_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
      bus.pixel_in = 24'h0; bus.pkt_valid = 1'b0;

      repeat (3) @(negedge pixel_clk);
      check_reset("por");
      rst = 1'b0;
      $display("step por: reset checked at cycle %0d", cyc);

      seg(100, 1'b0);
      a_s = last_idx - 99;
      $display("step idle: 100 blank cycles, pkt_valid=0");

      seg(30, 1'b0);
      seg(20, 1'b1);
      b_act = last_idx - 19;
      $display("step line: 30 blank + 20 active, first active input at %0d", b_act);

      pv_cur = 1'b1; drop_on_accept = 1'b1;
      seg(160, 1'b0);
      c_bl = last_idx - 159;
      seg(20, 1'b1);
      drop_on_accept = 1'b0;
      $display("step island160: blank starts at input %0d", c_bl);

      pv_cur = 1'b1;
      seg(57, 1'b0);
      d_bl = last_idx - 56;
      seg(20, 1'b1);
      d_act = last_idx - 19;
      $display("step blank57: blank starts at input %0d", d_bl);

      seg(200, 1'b0);
      e_bl = last_idx - 199;
      seg(20, 1'b1);
      $display("step blank200: blank starts at input %0d", e_bl);

      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         drive(1'b0);
         if (bus.mode === 3'd6 && bus.pkt_idx === 5'd10) found = 1'b1;
      end
      chk("island_idx10_seen", cyc, found, 1);
      rst = 1'b1;
      #1;
      check_reset("mid_island");
      repeat (3) drive(1'b0);
      check_reset("rst_held");
      rst = 1'b0;
      k_rdy = 0;
      for (int k = 1; k <= 100 && k_rdy == 0; k++) begin
         drive(1'b0);
         if (bus.pkt_ready === 1'b1) k_rdy = k;
      end
      chk("post_rst_ready_cycle", cyc, k_rdy, 5);
      chk("post_rst_mode", cyc, bus.mode, 4);
      chk("post_rst_ctl", cyc, bus.ctl, 4'b0101);
      $display("step reset_island: fresh pkt_ready %0d cycles after release", k_rdy);
      pv_cur = 1'b0;
      repeat (2) drive(1'b0);

      for (int i = a_s; i < a_s + 100; i++) begin
         chk("idle_mode", i, lg_mode[i], 0);
         chk("idle_rdy", i, lg_rdy[i], 0);
      end

      t0 = b_act + DELAY;
      chk("line_de_before", t0 - 1, lg_de[t0-1], 0);
      chk("line_de_rise", t0, lg_de[t0], 1);
      chk("line_pre_ctrl", t0 - 11, lg_mode[t0-11], 0);
      for (int i = 0; i < 8; i++) begin
         chk("line_vpre_mode", t0 - 10 + i, lg_mode[t0-10+i], 1);
         chk("line_vpre_ctl", t0 - 10 + i, lg_ctl[t0-10+i], 4'b0001);
      end
      for (int i = 2; i >= 1; i--) begin
         chk("line_vguard_mode", t0 - i, lg_mode[t0-i], 2);
         chk("line_vguard_ctl", t0 - i, lg_ctl[t0-i], 0);
      end
      for (int i = 0; i < 20; i++) begin
         chk("line_video_mode", t0 + i, lg_mode[t0+i], 3);
         chk("line_video_ctl", t0 + i, lg_ctl[t0+i], 0);
         chk("line_pixel", t0 + i, lg_pix[t0+i], in_pix[b_act+i]);
         chk("line_hsync", t0 + i, lg_hs[t0+i], in_hs[b_act+i]);
         chk("line_vsync", t0 + i, lg_vs[t0+i], in_vs[b_act+i]);
      end
      chk("line_end_mode", t0 + 20, lg_mode[t0+20], 0);
      chk("line_end_de", t0 + 20, lg_de[t0+20], 0);

      b0 = c_bl + DELAY;
      cnt = 0;
      for (int i = b0; i < b0 + 160; i++) if (lg_rdy[i] === 1'b1) cnt++;
      chk("i160_rdy_count", b0, cnt, 1);
      chk("i160_rdy_pos", b0 + 4, lg_rdy[b0+4], 1);
      for (int i = 0; i < 4; i++) chk("i160_lead_ctrl", b0 + i, lg_mode[b0+i], 0);
      for (int i = 0; i < 44; i++) begin
         exp_mode = (i < 8) ? 4 : (i < 10) ? 5 : (i < 42) ? 6 : 7;
         exp_ctl  = (i < 8) ? 5 : 0;
         exp_idx  = (i >= 10 && i < 42) ? i - 10 : 0;
         chk("i160_mode", b0 + 4 + i, lg_mode[b0+4+i], exp_mode);
         chk("i160_ctl", b0 + 4 + i, lg_ctl[b0+4+i], exp_ctl);
         chk("i160_idx", b0 + 4 + i, lg_idx[b0+4+i], exp_idx);
      end
      chk("i160_after", b0 + 48, lg_mode[b0+48], 0);
      chk("i160_vpre", b0 + 150, lg_mode[b0+150], 1);
      chk("i160_de_last_blank", b0 + 159, lg_de[b0+159], 0);
      chk("i160_de_rise", b0 + 160, lg_de[b0+160], 1);

      b0 = d_bl + DELAY;
      t0 = d_act + DELAY;
      cnt = 0;
      for (int i = b0; i < b0 + 57; i++) if (lg_rdy[i] === 1'b1) cnt++;
      chk("b57_rdy_count", b0, cnt, 0);
      chk("b57_no_island", b0 + 4, lg_mode[b0+4], 0);
      chk("b57_vpre_first", t0 - 10, lg_mode[t0-10], 1);
      chk("b57_vpre_ctl", t0 - 10, lg_ctl[t0-10], 4'b0001);
      chk("b57_vpre_last", t0 - 3, lg_mode[t0-3], 1);
      chk("b57_vguard", t0 - 2, lg_mode[t0-2], 2);
      chk("b57_vguard2", t0 - 1, lg_mode[t0-1], 2);
      chk("b57_video", t0, lg_mode[t0], 3);

      b0 = e_bl + DELAY;
      cnt = 0;
      for (int i = b0; i < b0 + 200; i++) if (lg_rdy[i] === 1'b1) cnt++;
      chk("b200_rdy_count", b0, cnt, 3);
      chk("b200_isl1", b0 + 4, lg_rdy[b0+4], 1);
      chk("b200_isl2", b0 + 52, lg_rdy[b0+52], 1);
      chk("b200_isl3", b0 + 100, lg_rdy[b0+100], 1);
      chk("b200_isl2_mode", b0 + 52, lg_mode[b0+52], 4);
      chk("b200_gap_ctrl", b0 + 51, lg_mode[b0+51], 0);
      chk("b200_isl3_tail", b0 + 143, lg_mode[b0+143], 7);
      chk("b200_no_isl4", b0 + 148, lg_mode[b0+148], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
